pmem_responder: RTL and testbench

PMEM_RESPONDER -- requirements
Module: pmem_responder

---
 rtl/pmem_responder.sv | 145 ++++++++++++++
 tb/tb_pmem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Line-granular memory responder with a fixed request-to-response latency.
// Optional protocol checking is compiled in with PMEM_PROTOCOL_CHECK_EN.
module pmem_responder #(
   parameter int LATENCY    = 8,
   parameter int INDEX_BITS = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [31:0]  pmem_address,
   input  logic [255:0] pmem_wdata,
   output logic [255:0] pmem_rdata,
   output logic         pmem_resp
`ifdef PMEM_PROTOCOL_CHECK_EN
   ,
   output logic         protocol_err
`endif
);

   localparam int        LINES  = 1 << INDEX_BITS;
   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   state_e                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [INDEX_BITS-1:0]   idx_q, idx_d;
   logic                    wr_q, wr_d;
   logic [255:0]            rdata_q, rdata_d;

   logic [255:0]            mem [LINES];

   logic [INDEX_BITS-1:0]   req_idx;
   logic                    req_any;
   logic                    cur_req;
   logic                    addr_unused;

   assign req_idx = pmem_address[5+INDEX_BITS-1:5];
   assign req_any = pmem_read | pmem_write;
   // The line only stays alive while the captured opcode's request stays high.
   assign cur_req = wr_q ? pmem_write : pmem_read;
   assign addr_unused = ^{pmem_address[31:5+INDEX_BITS],
                          pmem_address[4:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      unique case (state_q)
         IDLE: begin
            if (req_any) begin
               idx_d   = req_idx;
               wr_d    = pmem_write;
               cnt_d   = LAT_M1;
               state_d = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            if (!cur_req) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      rdata_d = rdata_q;
      if (state_d == RESP && state_q != RESP && !wr_d) begin
         rdata_d = mem[idx_d];
      end
   end

   always_comb begin
      pmem_resp  = (state_q == RESP);
      pmem_rdata = rdata_q;
   end

   // Storage is deliberately left out of reset so contents survive it.
   always_ff @(posedge clk) begin
      if (state_q == RESP && wr_q) begin
         mem[idx_q] <= pmem_wdata;
      end
   end

`ifdef PMEM_PROTOCOL_CHECK_EN
   logic err_q, err_d;
   logic other_req;
   logic viol;

   assign other_req = wr_q ? pmem_read : pmem_write;

   always_comb begin
      viol = 1'b0;
      if (state_q == IDLE && pmem_read && pmem_write) begin
         viol = 1'b1;
      end
      if (state_q == BUSY && (!cur_req || other_req)) begin
         viol = 1'b1;
      end
      err_d = err_q | viol;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign protocol_err = err_q;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench: LATENCY=8 instance for main behaviour,
// LATENCY=1 instance for the direct IDLE->RESP path.
module tb_pmem_responder;

   localparam int L = 8;

   logic         clk;
   logic         rst_n;
   logic         a_read, a_write;
   logic [31:0]  a_addr;
   logic [255:0] a_wdata, a_rdata;
   logic         a_resp;
   logic         b_read, b_write;
   logic [31:0]  b_addr;
   logic [255:0] b_wdata, b_rdata;
   logic         b_resp;
`ifdef PMEM_PROTOCOL_CHECK_EN
   logic         a_err, b_err;
`endif

   int n_chk;
   int n_err;

   pmem_responder #(.LATENCY(L), .INDEX_BITS(6)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pmem_read    (a_read),
      .pmem_write   (a_write),
      .pmem_address (a_addr),
      .pmem_wdata   (a_wdata),
      .pmem_rdata   (a_rdata),
      .pmem_resp    (a_resp)
`ifdef PMEM_PROTOCOL_CHECK_EN
      ,
      .protocol_err (a_err)
`endif
   );

   pmem_responder #(.LATENCY(1), .INDEX_BITS(6)) u_dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .pmem_read    (b_read),
      .pmem_write   (b_write),
      .pmem_address (b_addr),
      .pmem_wdata   (b_wdata),
      .pmem_rdata   (b_rdata),
      .pmem_resp    (b_resp)
`ifdef PMEM_PROTOCOL_CHECK_EN
      ,
      .protocol_err (b_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [255:0] obs,
                        input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic txn(input logic rd, input logic wr,
                      input logic [31:0] addr,
                      input logic [255:0] wd,
                      output int lat,
                      output logic [255:0] rd_o);
      @(posedge clk); #1;
      a_read  = rd;
      a_write = wr;
      a_addr  = addr;
      a_wdata = wd;
      lat  = -1;
      rd_o = '0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (a_resp) begin
            lat  = k;
            rd_o = a_rdata;
            break;
         end
      end
      a_read  = 1'b0;
      a_write = 1'b0;
   endtask

   task automatic do_wr(input string tag, input logic [31:0] addr,
                        input logic [255:0] wd);
      int lat;
      logic [255:0] d;
      txn(1'b0, 1'b1, addr, wd, lat, d);
      check({tag, "_lat"}, 256'(lat), 256'(L));
   endtask

   task automatic do_rd(input string tag, input logic [31:0] addr,
                        input logic [255:0] exp);
      int lat;
      logic [255:0] d;
      txn(1'b1, 1'b0, addr, '0, lat, d);
      check({tag, "_lat"}, 256'(lat), 256'(L));
      check({tag, "_data"}, d, exp);
   endtask

   logic [255:0] pa5, p12, p55, pff, p77, p3c;
   int cnt;
   int lat;
   logic [255:0] d;

   initial begin
      n_chk = 0;
      n_err = 0;
      pa5 = {32{8'hA5}};
      p55 = {32{8'h55}};
      pff = {32{8'hFF}};
      p77 = {32{8'h77}};
      p3c = {32{8'h3C}};
      p12 = 256'h1234;
      rst_n   = 1'b0;
      a_read  = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
      b_read  = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_resp", 256'(a_resp), 256'(0));
      check("rst_rdata", a_rdata, '0);
`ifdef PMEM_PROTOCOL_CHECK_EN
      check("rst_err", 256'(a_err), 256'(0));
`endif
      rst_n = 1'b1;

      do_wr("wr40", 32'h40, pa5);
      do_rd("rd40", 32'h40, pa5);

      do_wr("wr20", 32'h20, p3c);
      do_rd("rd820_alias", 32'h820, p3c);

      // read dropped at cycle 3
      @(posedge clk); #1;
      a_read = 1'b1; a_addr = 32'h40;
      repeat (3) begin
         @(posedge clk); #1;
      end
      a_read = 1'b0;
      cnt = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (a_resp) cnt++;
      end
      check("abort_resp", 256'(cnt), 256'(0));
`ifdef PMEM_PROTOCOL_CHECK_EN
      check("abort_err", 256'(a_err), 256'(1));
`endif

      // read+write together: write wins
      txn(1'b1, 1'b1, 32'h60, p12, lat, d);
      check("rw60_lat", 256'(lat), 256'(L));
      do_rd("rd60", 32'h60, p12);

      // address/opcode changes during BUSY are ignored
      @(posedge clk); #1;
      a_read = 1'b1; a_addr = 32'h40; a_wdata = pff;
      repeat (2) begin
         @(posedge clk); #1;
      end
      a_addr = 32'h20; a_write = 1'b1;
      lat = -1;
      for (int k = 3; k <= 40; k++) begin
         @(posedge clk); #1;
         if (a_resp) begin
            lat = k; d = a_rdata; break;
         end
      end
      a_read = 1'b0; a_write = 1'b0;
      check("chg_lat", 256'(lat), 256'(L));
      check("chg_data", d, pa5);
      do_rd("rd20_kept", 32'h20, p3c);

      // reset in the middle of a write
      do_wr("wr80", 32'h80, p55);
      @(posedge clk); #1;
      a_write = 1'b1; a_addr = 32'h80; a_wdata = pff;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("mid_rst_rdata", a_rdata, '0);
`ifdef PMEM_PROTOCOL_CHECK_EN
      check("mid_rst_err", 256'(a_err), 256'(0));
`endif
      cnt = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (a_resp) cnt++;
      end
      check("mid_rst_resp", 256'(cnt), 256'(0));
      a_write = 1'b0;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      a_read = 1'b1; a_addr = 32'h80;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (a_resp) begin
            lat = k; d = a_rdata; break;
         end
      end
      a_read = 1'b0;
      check("post_rst_lat", 256'(lat), 256'(L));
      check("post_rst_data", d, p55);

      // LATENCY=1 instance
      @(posedge clk); #1;
      b_write = 1'b1; b_addr = 32'h60; b_wdata = p77;
      @(posedge clk); #1;
      check("l1_wr_resp", 256'(b_resp), 256'(1));
      b_write = 1'b0;
      @(posedge clk); #1;
      b_read = 1'b1; b_addr = 32'h60;
      @(posedge clk); #1;
      check("l1_rd0_resp", 256'(b_resp), 256'(1));
      check("l1_rd0_data", b_rdata, p77);
      b_read = 1'b0;
      @(posedge clk); #1;
      check("l1_gap_resp", 256'(b_resp), 256'(0));
      b_read = 1'b1;
      @(posedge clk); #1;
      check("l1_rd2_resp", 256'(b_resp), 256'(1));
      check("l1_rd2_data", b_rdata, p77);
      b_read = 1'b0;
      @(posedge clk); #1;
      check("l1_idle_resp", 256'(b_resp), 256'(0));
      check("l1_hold_data", b_rdata, p77);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
